track_frame_ctrl: RTL and testbench

Frame-level controller that sits between the camera/grayscale pixel stream and the colour tracker. It admits one frame out of every `cfg_skip+1` into the tracker. Pixels of a short frame are padded so the tracker's internal raster counter stays aligned. Each admitted frame ends with the tracker reporting a target or the controller timing out, and the block then holds a stable, lock-qualified bounding box for the overlay/servo logic.

---
 rtl/track_frame_if.sv | 12 +
 rtl/track_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_track_frame_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/track_frame_if.sv
// track_frame_if: source pixel stream between the camera/grayscale front end and the frame controller
interface track_frame_if;
    logic       valid;
    logic       sof;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       ready;

    modport master (output valid, sof, r, g, b, input ready);
    modport slave  (input valid, sof, r, g, b, output ready);
endinterface

// File: rtl/track_frame_ctrl.sv
// track_frame_ctrl: admits every (cfg_skip+1)-th frame to the colour tracker, pads short frames and holds a lock-qualified result
module track_frame_ctrl #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int TIMEOUT    = 8192,
    parameter int MISS_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    track_frame_if.slave pix,
    input  logic [3:0]   cfg_skip_i,
    output logic         trk_wr_en_o,
    output logic [7:0]   trk_r_o,
    output logic [7:0]   trk_g_o,
    output logic [7:0]   trk_b_o,
    input  logic         trk_full_i,
    input  logic         trk_valid_i,
    input  logic [11:0]  trk_cx_i,
    input  logic [11:0]  trk_cy_i,
    input  logic [11:0]  trk_w_i,
    input  logic [11:0]  trk_h_i,
    output logic [11:0]  obj_x_o,
    output logic [11:0]  obj_y_o,
    output logic [11:0]  obj_w_o,
    output logic [11:0]  obj_h_o,
    output logic         obj_lock_o,
    output logic         frame_done_o,
    output logic         sync_err_o,
    output logic [15:0]  frame_cnt_o
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(NPIX);
    localparam int TW   = $clog2(TIMEOUT);
    localparam int MW   = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, PASS, PAD, WAIT} state_t;

    state_t        state_q;
    logic [PW-1:0] pix_cnt_q;
    logic [3:0]    skip_q;
    logic [TW-1:0] tmr_q;
    logic [MW-1:0] miss_q;
    logic [11:0]   obj_x_q;
    logic [11:0]   obj_y_q;
    logic [11:0]   obj_w_q;
    logic [11:0]   obj_h_q;
    logic          obj_lock_q;
    logic          frame_done_q;
    logic          sync_err_q;
    logic [15:0]   frame_cnt_q;
    logic          sof_seen;
    logic          admit;
    logic          last_pix;
    logic          timeout;

    assign sof_seen = pix.valid & pix.sof;
    // rst_n gate keeps the tracker write low while reset is held with an SOF on the input
    assign admit    = rst_n & (state_q == IDLE) & sof_seen & (skip_q == 4'd0);
    // counter holds the number already written, so the frame's final write happens at NPIX-1
    assign last_pix = pix_cnt_q == PW'(NPIX - 1);
    assign timeout  = tmr_q == TW'(TIMEOUT - 1);

    // Zero-latency pixel path: ready, write strobe and tracker pixel depend only on state, inputs and trk_full
    always_comb begin
        pix.ready   = (state_q == PASS) ? (~trk_full_i & ~sof_seen) : (state_q != PAD);
        trk_wr_en_o = (state_q == PAD)  ? ~trk_full_i :
                      (state_q == PASS) ? (pix.valid & pix.ready) : admit;
        trk_r_o     = (state_q == PAD) ? 8'd0 : pix.r;
        trk_g_o     = (state_q == PAD) ? 8'd0 : pix.g;
        trk_b_o     = (state_q == PAD) ? 8'd0 : pix.b;
    end

    // Frame FSM: admission, pass-through counting, padding, result wait and held-result bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            skip_q       <= '0;
            tmr_q        <= '0;
            miss_q       <= '0;
            obj_x_q      <= '0;
            obj_y_q      <= '0;
            obj_w_q      <= '0;
            obj_h_q      <= '0;
            obj_lock_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sof_seen && skip_q == 4'd0) begin
                        skip_q    <= cfg_skip_i;
                        pix_cnt_q <= PW'(1);
                        state_q   <= PASS;
                    end else if (sof_seen) begin
                        skip_q <= skip_q - 4'd1;
                    end
                end
                PASS: begin
                    if (sof_seen) begin
                        sync_err_q <= 1'b1;
                        state_q    <= PAD;
                    end else if (trk_wr_en_o) begin
                        pix_cnt_q <= pix_cnt_q + PW'(1);
                        if (last_pix) begin
                            tmr_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                end
                PAD: begin
                    if (!trk_full_i) begin
                        pix_cnt_q <= pix_cnt_q + PW'(1);
                        if (last_pix) begin
                            tmr_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                end
                default: begin
                    if (sof_seen)
                        sync_err_q <= 1'b1;
                    if (trk_valid_i) begin
                        obj_x_q      <= trk_cx_i;
                        obj_y_q      <= trk_cy_i;
                        obj_w_q      <= trk_w_i;
                        obj_h_q      <= trk_h_i;
                        obj_lock_q   <= 1'b1;
                        miss_q       <= '0;
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + 16'd1;
                        state_q      <= IDLE;
                    end else if (timeout) begin
                        if (miss_q != MW'(MISS_LIMIT))
                            miss_q <= miss_q + MW'(1);
                        if (miss_q >= MW'(MISS_LIMIT - 1))
                            obj_lock_q <= 1'b0;
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + 16'd1;
                        state_q      <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
            endcase
        end
    end

    assign obj_x_o      = obj_x_q;
    assign obj_y_o      = obj_y_q;
    assign obj_w_o      = obj_w_q;
    assign obj_h_o      = obj_h_q;
    assign obj_lock_o   = obj_lock_q;
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;
    assign frame_cnt_o  = frame_cnt_q;
endmodule

// File: tb/tb_track_frame_ctrl.sv
// tb_track_frame_ctrl: randomized frame scenarios against a bounding-box tracker model and frame-level reference
module tb_track_frame_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int TO = 64;
    localparam int ML = 2;

    typedef struct {bit has; int x0; int y0; int x1; int y1;} box_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cfg_skip = 4'd0;
    logic        trk_wr_en;
    logic [7:0]  trk_r, trk_g, trk_b;
    logic        trk_full = 1'b0;
    logic        trk_valid;
    logic [11:0] trk_cx, trk_cy, trk_w, trk_h;
    logic [11:0] obj_x, obj_y, obj_w, obj_h;
    logic        obj_lock, frame_done, sync_err;
    logic [15:0] frame_cnt;

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0;
    int t_cnt = 0, t_lat = 0, t_minx, t_maxx, t_miny, t_maxy, t_x, t_y;
    bit t_found = 0;

    track_frame_if pix();

    track_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO), .MISS_LIMIT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .pix(pix), .cfg_skip_i(cfg_skip),
        .trk_wr_en_o(trk_wr_en), .trk_r_o(trk_r), .trk_g_o(trk_g), .trk_b_o(trk_b),
        .trk_full_i(trk_full), .trk_valid_i(trk_valid),
        .trk_cx_i(trk_cx), .trk_cy_i(trk_cy), .trk_w_i(trk_w), .trk_h_i(trk_h),
        .obj_x_o(obj_x), .obj_y_o(obj_y), .obj_w_o(obj_w), .obj_h_o(obj_h),
        .obj_lock_o(obj_lock), .frame_done_o(frame_done), .sync_err_o(sync_err),
        .frame_cnt_o(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Colour tracker stand-in: raster-counts writes, boxes green pixels, reports after a random latency
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (!rst_n) begin
            t_cnt = 0; t_found = 0; t_lat = 0; trk_valid = 1'b0;
            trk_cx = '0; trk_cy = '0; trk_w = '0; trk_h = '0;
        end else begin
            trk_valid = 1'b0;
            if (t_lat > 0) begin
                t_lat--;
                if (t_lat == 0) trk_valid = 1'b1;
            end
            if (trk_wr_en) begin
                wr_cnt++;
                t_x = t_cnt % W;
                t_y = t_cnt / W;
                if (trk_g >= 8'd128 && trk_r < 8'd64 && trk_b < 8'd64) begin
                    if (!t_found) begin
                        t_minx = t_x; t_maxx = t_x; t_miny = t_y; t_maxy = t_y;
                    end else begin
                        if (t_x < t_minx) t_minx = t_x;
                        if (t_x > t_maxx) t_maxx = t_x;
                        if (t_y < t_miny) t_miny = t_y;
                        if (t_y > t_maxy) t_maxy = t_y;
                    end
                    t_found = 1;
                end
                t_cnt++;
                if (t_cnt == N) begin
                    if (t_found) begin
                        trk_cx = 12'((t_minx + t_maxx) / 2);
                        trk_cy = 12'((t_miny + t_maxy) / 2);
                        trk_w  = 12'(t_maxx - t_minx + 1);
                        trk_h  = 12'(t_maxy - t_miny + 1);
                        t_lat  = $urandom_range(1, 12);
                    end
                    t_cnt = 0;
                    t_found = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic box_t mk(input bit has, input int x0, input int y0, input int x1, input int y1);
        box_t b;
        b.has = has; b.x0 = x0; b.y0 = y0; b.x1 = x1; b.y1 = y1;
        return b;
    endfunction

    function automatic logic [23:0] pix_of(input int i, input box_t b);
        int x, y;
        x = i % W;
        y = i / W;
        return (b.has && x >= b.x0 && x <= b.x1 && y >= b.y0 && y <= b.y1) ? {8'd20, 8'd200, 8'd20} : {8'd30, 8'd30, 8'd30};
    endfunction

    function automatic logic [47:0] exp_obj(input box_t b);
        return {12'((b.x0 + b.x1) / 2), 12'((b.y0 + b.y1) / 2), 12'(b.x1 - b.x0 + 1), 12'(b.y1 - b.y0 + 1)};
    endfunction

    task automatic do_reset();
        pix.valid = 0; pix.sof = 0; pix.r = 0; pix.g = 0; pix.b = 0;
        trk_full = 0; cfg_skip = 0;
        @(posedge clk); #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic send_pixel(input bit sof, input logic [23:0] c, output bit ok);
        int n;
        bit acc;
        n = 0; acc = 0;
        pix.valid = 1; pix.sof = sof; {pix.r, pix.g, pix.b} = c;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = pix.ready;
            @(posedge clk); #1;
            n++;
        end
        pix.valid = 0; pix.sof = 0;
        ok = acc;
    endtask

    task automatic stall(input logic [23:0] c, input int len, inout int bad);
        pix.valid = 1; pix.sof = 0; {pix.r, pix.g, pix.b} = c;
        trk_full = 1;
        repeat (len) begin
            @(negedge clk);
            if (trk_wr_en !== 1'b0 || pix.ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        trk_full = 0;
        pix.valid = 0;
    endtask

    task automatic send_frame(input box_t b, input int npix, input bit gaps, input int stall_at,
                              input int stall_len, output int t_last, inout int bad);
        bit ok;
        t_last = 0;
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            if (i == stall_at) stall(pix_of(i, b), stall_len, bad);
            send_pixel(i == 0, pix_of(i, b), ok);
            total_cnt++;
            if (!ok) $display("FAIL accept pixel %0d: got not accepted, want accepted", i); else pass_cnt++;
            t_last = cyc;
        end
    endtask

    task automatic wait_done(output bit got, output int t);
        got = 0; t = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (frame_done) begin got = 1; t = cyc; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total_cnt++; if (pix.ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", pix.ready); else pass_cnt++;
        total_cnt++; if (trk_wr_en !== 1'b0) $display("FAIL reset trk_wr_en: got %b want 0", trk_wr_en); else pass_cnt++;
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== 48'd0) $display("FAIL reset obj: got %h want 0", {obj_x, obj_y, obj_w, obj_h}); else pass_cnt++;
        total_cnt++; if ({obj_lock, frame_done, sync_err} !== 3'b000) $display("FAIL reset flags: got %b want 000", {obj_lock, frame_done, sync_err}); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd0) $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_green();
        box_t b;
        int w0, t0, t1, bad;
        bit got;
        do_reset();
        b = mk(1, 2, 1, 2, 1);
        w0 = wr_cnt; bad = 0;
        send_frame(b, N, 0, -1, 0, t0, bad);
        wait_done(got, t1);
        total_cnt++; if (!got) $display("FAIL single frame_done: got none want pulse"); else pass_cnt++;
        total_cnt++; if (wr_cnt - w0 != N) $display("FAIL single writes: got %0d want %0d", wr_cnt - w0, N); else pass_cnt++;
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== {12'd2, 12'd1, 12'd1, 12'd1}) $display("FAIL single obj: got %0d,%0d,%0d,%0d want 2,1,1,1", obj_x, obj_y, obj_w, obj_h); else pass_cnt++;
        total_cnt++; if (obj_lock !== 1'b1) $display("FAIL single lock: got %b want 1", obj_lock); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL single frame_cnt: got %0d want 1", frame_cnt); else pass_cnt++;
        total_cnt++; if (sync_err !== 1'b0) $display("FAIL single sync_err: got %b want 0", sync_err); else pass_cnt++;
    endtask

    task automatic test_random_frames();
        box_t b;
        int w0, t0, t1, bad, miss;
        bit got, elock;
        logic [47:0] eobj;
        do_reset();
        eobj = '0; elock = 0; miss = 0;
        for (int f = 0; f < 8; f++) begin
            b.has = $urandom_range(0, 3) != 0;
            b.x0 = $urandom_range(0, W - 1); b.x1 = $urandom_range(b.x0, W - 1);
            b.y0 = $urandom_range(0, H - 1); b.y1 = $urandom_range(b.y0, H - 1);
            w0 = wr_cnt; bad = 0;
            send_frame(b, N, 1, $urandom_range(1, N - 1), $urandom_range(1, 4), t0, bad);
            wait_done(got, t1);
            if (b.has) begin
                eobj = exp_obj(b); elock = 1; miss = 0;
            end else begin
                miss = (miss < ML) ? miss + 1 : ML;
                if (miss >= ML) elock = 0;
            end
            total_cnt++; if (!got) $display("FAIL rand%0d frame_done: got none want pulse", f); else pass_cnt++;
            total_cnt++; if (wr_cnt - w0 != N) $display("FAIL rand%0d writes: got %0d want %0d", f, wr_cnt - w0, N); else pass_cnt++;
            total_cnt++; if (bad != 0) $display("FAIL rand%0d stall: got %0d writes/ready during full want 0", f, bad); else pass_cnt++;
            total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== eobj) $display("FAIL rand%0d obj: got %h want %h", f, {obj_x, obj_y, obj_w, obj_h}, eobj); else pass_cnt++;
            total_cnt++; if (obj_lock !== elock) $display("FAIL rand%0d lock: got %b want %b", f, obj_lock, elock); else pass_cnt++;
            total_cnt++; if (frame_cnt !== 16'(f + 1)) $display("FAIL rand%0d frame_cnt: got %0d want %0d", f, frame_cnt, f + 1); else pass_cnt++;
            if (!b.has) begin
                total_cnt++; if (t1 - t0 != TO) $display("FAIL rand%0d timeout: got %0d cycles want %0d", f, t1 - t0, TO); else pass_cnt++;
            end
        end
        total_cnt++; if (sync_err !== 1'b0) $display("FAIL rand sync_err: got %b want 0", sync_err); else pass_cnt++;
    endtask

    task automatic test_frame_skip();
        box_t b;
        int w0, wf, d0, t0, t1, bad;
        bit got;
        do_reset();
        cfg_skip = 4'd2;
        w0 = wr_cnt; d0 = done_cnt; bad = 0;
        for (int f = 0; f < 6; f++) begin
            b = mk(1, f, f % H, f, f % H);
            wf = wr_cnt;
            send_frame(b, N, 0, -1, 0, t0, bad);
            if (f % 3 == 0) begin
                wait_done(got, t1);
                total_cnt++; if (!got) $display("FAIL skip%0d frame_done: got none want pulse", f); else pass_cnt++;
                total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== exp_obj(b)) $display("FAIL skip%0d obj: got %h want %h", f, {obj_x, obj_y, obj_w, obj_h}, exp_obj(b)); else pass_cnt++;
            end else begin
                repeat (3) begin @(posedge clk); #1; end
                total_cnt++; if (wr_cnt != wf) $display("FAIL skip%0d dropped: got %0d writes want 0", f, wr_cnt - wf); else pass_cnt++;
            end
        end
        repeat (80) begin @(posedge clk); #1; end
        total_cnt++; if (frame_cnt !== 16'd2) $display("FAIL skip frame_cnt: got %0d want 2", frame_cnt); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 2) $display("FAIL skip frame_done count: got %0d want 2", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (wr_cnt - w0 != 2 * N) $display("FAIL skip writes: got %0d want %0d", wr_cnt - w0, 2 * N); else pass_cnt++;
        total_cnt++; if (sync_err !== 1'b0) $display("FAIL skip sync_err: got %b want 0", sync_err); else pass_cnt++;
    endtask

    task automatic test_short_frame();
        box_t b;
        int t0, t1, bad, pads, nz;
        bit got;
        do_reset();
        b = mk(1, 3, 0, 3, 0);
        bad = 0; pads = 0; nz = 0;
        send_frame(b, 20, 0, -1, 0, t0, bad);
        pix.valid = 1; pix.sof = 1; {pix.r, pix.g, pix.b} = {8'd30, 8'd30, 8'd30};
        @(negedge clk);
        total_cnt++; if (pix.ready !== 1'b0) $display("FAIL short sof held: got ready %b want 0", pix.ready); else pass_cnt++;
        @(posedge clk); #1;
        pix.valid = 0; pix.sof = 0;
        got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (trk_wr_en) begin
                pads++;
                if ({trk_r, trk_g, trk_b} != 24'd0) nz++;
                if (pix.ready !== 1'b0) bad++;
            end
            if (frame_done) got = 1;
        end
        @(posedge clk); #1;
        total_cnt++; if (pads != N - 20) $display("FAIL short pad count: got %0d want %0d", pads, N - 20); else pass_cnt++;
        total_cnt++; if (nz != 0) $display("FAIL short pad colour: got %0d nonzero want 0", nz); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL short pad ready: got %0d ready-high cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (!got) $display("FAIL short frame_done: got none want pulse"); else pass_cnt++;
        total_cnt++; if (sync_err !== 1'b1) $display("FAIL short sync_err: got %b want 1", sync_err); else pass_cnt++;
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== exp_obj(b)) $display("FAIL short obj: got %h want %h", {obj_x, obj_y, obj_w, obj_h}, exp_obj(b)); else pass_cnt++;
        b = mk(1, 5, 2, 5, 2);
        send_frame(b, N, 0, -1, 0, t0, bad);
        wait_done(got, t1);
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== exp_obj(b)) $display("FAIL short next obj: got %h want %h", {obj_x, obj_y, obj_w, obj_h}, exp_obj(b)); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd2) $display("FAIL short frame_cnt: got %0d want 2", frame_cnt); else pass_cnt++;
    endtask

    task automatic test_lock_loss();
        box_t b;
        int t0, t1, bad;
        bit got;
        do_reset();
        bad = 0;
        send_frame(mk(1, 1, 1, 1, 1), N, 0, -1, 0, t0, bad);
        wait_done(got, t1);
        total_cnt++; if (obj_lock !== 1'b1) $display("FAIL lock hit: got %b want 1", obj_lock); else pass_cnt++;
        b = mk(0, 0, 0, 0, 0);
        for (int k = 1; k <= ML; k++) begin
            send_frame(b, N, 0, -1, 0, t0, bad);
            wait_done(got, t1);
            total_cnt++; if (!got || t1 - t0 != TO) $display("FAIL lock miss%0d timeout: got %0d cycles want %0d", k, got ? t1 - t0 : -1, TO); else pass_cnt++;
            total_cnt++; if (obj_lock !== (k < ML)) $display("FAIL lock miss%0d lock: got %b want %b", k, obj_lock, k < ML); else pass_cnt++;
            total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== {12'd1, 12'd1, 12'd1, 12'd1}) $display("FAIL lock miss%0d obj: got %h want held 1,1,1,1", k, {obj_x, obj_y, obj_w, obj_h}); else pass_cnt++;
        end
        total_cnt++; if (frame_cnt !== 16'(ML + 1)) $display("FAIL lock frame_cnt: got %0d want %0d", frame_cnt, ML + 1); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        box_t b;
        int w0, t0, t1, bad;
        bit got;
        do_reset();
        b = mk(1, 6, 3, 6, 3);
        w0 = wr_cnt; bad = 0;
        send_frame(b, N, 0, 10, 10, t0, bad);
        wait_done(got, t1);
        total_cnt++; if (bad != 0) $display("FAIL bp stall: got %0d writes/ready during full want 0", bad); else pass_cnt++;
        total_cnt++; if (wr_cnt - w0 != N) $display("FAIL bp writes: got %0d want %0d", wr_cnt - w0, N); else pass_cnt++;
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== exp_obj(b)) $display("FAIL bp obj: got %h want %h", {obj_x, obj_y, obj_w, obj_h}, exp_obj(b)); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        box_t b;
        int w0, t0, t1, bad;
        bit got;
        do_reset();
        bad = 0;
        b = mk(1, 4, 2, 4, 2);
        send_frame(b, N, 0, -1, 0, t0, bad);
        wait_done(got, t1);
        send_frame(b, 10, 0, -1, 0, t0, bad);
        pix.valid = 1; pix.sof = 0; {pix.r, pix.g, pix.b} = {8'd30, 8'd30, 8'd30};
        #3 rst_n = 0;
        #1;
        total_cnt++; if (pix.ready !== 1'b1 || trk_wr_en !== 1'b0) $display("FAIL areset ready/wr: got %b%b want 10", pix.ready, trk_wr_en); else pass_cnt++;
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== 48'd0) $display("FAIL areset obj: got %h want 0", {obj_x, obj_y, obj_w, obj_h}); else pass_cnt++;
        total_cnt++; if ({obj_lock, frame_done, sync_err} !== 3'b000 || frame_cnt !== 16'd0) $display("FAIL areset flags/cnt: got %b/%0d want 000/0", {obj_lock, frame_done, sync_err}, frame_cnt); else pass_cnt++;
        pix.valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        w0 = wr_cnt;
        b = mk(1, 7, 0, 7, 0);
        send_frame(b, N, 0, -1, 0, t0, bad);
        wait_done(got, t1);
        total_cnt++; if (wr_cnt - w0 != N) $display("FAIL areset writes: got %0d want %0d", wr_cnt - w0, N); else pass_cnt++;
        total_cnt++; if ({obj_x, obj_y, obj_w, obj_h} !== exp_obj(b)) $display("FAIL areset obj after: got %h want %h", {obj_x, obj_y, obj_w, obj_h}, exp_obj(b)); else pass_cnt++;
        total_cnt++; if (frame_cnt !== 16'd1) $display("FAIL areset frame_cnt: got %0d want 1", frame_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_green();
        test_random_frames();
        test_frame_skip();
        test_short_frame();
        test_lock_loss();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
